// File: rtl/lcd_responder_pkg.sv
// Shared definitions for the HD44780-style LCD bus responder: FSM states,
// instruction classes, and the blank character used by clear.
package lcd_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_FILL,
    ST_WAIT
  } state_e;

  typedef enum logic [3:0] {
    IC_NOP,
    IC_CLEAR,
    IC_HOME,
    IC_ENTRY,
    IC_DISP,
    IC_SHIFT,
    IC_FUNC,
    IC_CGRAM,
    IC_DDRAM
  } instr_e;

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int         TIMER_W    = 17;

  // The instruction class is selected by the highest set bit of the opcode.
  function automatic instr_e decode_instr(input logic [7:0] op);
    if (op[7])      return IC_DDRAM;
    else if (op[6]) return IC_CGRAM;
    else if (op[5]) return IC_FUNC;
    else if (op[4]) return IC_SHIFT;
    else if (op[3]) return IC_DISP;
    else if (op[2]) return IC_ENTRY;
    else if (op[1]) return IC_HOME;
    else if (op[0]) return IC_CLEAR;
    else            return IC_NOP;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// Display data RAM: one write port, an asynchronous read port for the bus and
// a registered read port for the renderer. Contents are not reset.
module lcd_ddram #(
  parameter int DEPTH = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [6:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [6:0] baddr_i,
  output logic [7:0] bdata_o,
  input  logic [6:0] raddr_i,
  output logic [7:0] rdata_o
);

  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  logic [7:0] mem_q [DEPTH];
  logic       wr_ok;
  logic       bus_ok;
  logic       rd_ok;

  assign wr_ok  = ({1'b0, waddr_i} < DEPTH_L);
  assign bus_ok = ({1'b0, baddr_i} < DEPTH_L);
  assign rd_ok  = ({1'b0, raddr_i} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (we_i && wr_ok) mem_q[waddr_i] <= wdata_i;
  end

  assign bdata_o = bus_ok ? mem_q[baddr_i] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata_o <= 8'h00;
    else if (rd_ok) rdata_o <= mem_q[raddr_i];
    else            rdata_o <= 8'h00;
  end

endmodule

// File: rtl/lcd_responder.sv
// Character-LCD controller model: accepts bus transfers on the falling edge of
// lcd_enable, executes instructions/data writes and holds busy for the command time.
module lcd_responder
  import lcd_responder_pkg::*;
#(
  parameter int SHORT_WAIT  = 2_000,
  parameter int LONG_WAIT   = 40_000,
  parameter int DDRAM_DEPTH = 80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_enable,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       busy,
  output logic       display_on,
  output logic [6:0] cursor_addr,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       overrun
);

  localparam logic [6:0]         AC_LAST    = 7'(DDRAM_DEPTH - 1);
  localparam logic [7:0]         DEPTH_L    = 8'(DDRAM_DEPTH);
  localparam logic [TIMER_W-1:0] SHORT_LOAD = TIMER_W'(SHORT_WAIT);
  localparam logic [TIMER_W-1:0] LONG_LOAD  = TIMER_W'(LONG_WAIT);

  state_e             state_q;
  logic               en_prev_q;
  logic [6:0]         ac_q;
  logic               id_q, s_q, d_q, c_q, b_q, dl_q, n_q, f_q;
  logic               overrun_q;
  logic               rs_q;
  logic [7:0]         cmd_q;
  logic [6:0]         fill_addr_q;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] load_q;

  logic               accept_d;
  logic               idle_d;
  logic               we_d;
  logic [6:0]         waddr_d;
  logic [7:0]         wdata_d;
  logic [7:0]         bus_rdata_d;
  logic               unused_mode;

  function automatic logic [6:0] step_ac(input logic [6:0] a, input logic inc);
    if (inc) return (a == AC_LAST) ? 7'd0 : a + 7'd1;
    else     return (a == 7'd0) ? AC_LAST : a - 7'd1;
  endfunction

  assign accept_d = en_prev_q & ~lcd_enable;
  assign idle_d   = (state_q == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      en_prev_q   <= 1'b0;
      ac_q        <= 7'd0;
      id_q        <= 1'b1;
      s_q         <= 1'b0;
      d_q         <= 1'b0;
      c_q         <= 1'b0;
      b_q         <= 1'b0;
      dl_q        <= 1'b0;
      n_q         <= 1'b0;
      f_q         <= 1'b0;
      overrun_q   <= 1'b0;
      rs_q        <= 1'b0;
      cmd_q       <= 8'h00;
      fill_addr_q <= 7'd0;
      timer_q     <= '0;
      load_q      <= '0;
    end else begin
      en_prev_q <= lcd_enable;
      if (accept_d && !lcd_rw && !idle_d) overrun_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            if (!lcd_rw) begin
              rs_q  <= lcd_rs;
              cmd_q <= lcd_data_in;
              if (lcd_rs) begin
                state_q <= ST_EXEC;
              end else if (decode_instr(lcd_data_in) == IC_CLEAR) begin
                state_q     <= ST_FILL;
                fill_addr_q <= 7'd0;
              end else if (decode_instr(lcd_data_in) != IC_NOP) begin
                state_q <= ST_EXEC;
              end
            end else if (lcd_rs) begin
              ac_q <= step_ac(ac_q, id_q);
            end
          end
        end

        ST_EXEC: begin
          state_q <= ST_WAIT;
          timer_q <= TIMER_W'(1);
          load_q  <= SHORT_LOAD;
          if (rs_q) begin
            ac_q <= step_ac(ac_q, id_q);
          end else begin
            case (decode_instr(cmd_q))
              IC_HOME: begin
                ac_q   <= 7'd0;
                load_q <= LONG_LOAD;
              end
              IC_ENTRY: begin
                id_q <= cmd_q[1];
                s_q  <= cmd_q[0];
              end
              IC_DISP: begin
                d_q <= cmd_q[2];
                c_q <= cmd_q[1];
                b_q <= cmd_q[0];
              end
              IC_SHIFT: if (!cmd_q[3]) ac_q <= step_ac(ac_q, cmd_q[2]);
              IC_FUNC: begin
                dl_q <= cmd_q[4];
                n_q  <= cmd_q[3];
                f_q  <= cmd_q[2];
              end
              IC_DDRAM: ac_q <= ({1'b0, cmd_q[6:0]} >= DEPTH_L) ? 7'd0 : cmd_q[6:0];
              default: ;
            endcase
          end
        end

        // One blank written per cycle; the last one hands over to the long wait.
        ST_FILL: begin
          if (fill_addr_q == AC_LAST) begin
            ac_q    <= 7'd0;
            id_q    <= 1'b1;
            state_q <= ST_WAIT;
            timer_q <= TIMER_W'(1);
            load_q  <= LONG_LOAD;
          end else begin
            fill_addr_q <= fill_addr_q + 7'd1;
          end
        end

        ST_WAIT: begin
          if (timer_q >= load_q) state_q <= ST_IDLE;
          else                   timer_q <= timer_q + TIMER_W'(1);
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign we_d    = (state_q == ST_FILL) || ((state_q == ST_EXEC) && rs_q);
  assign waddr_d = (state_q == ST_FILL) ? fill_addr_q : ac_q;
  assign wdata_d = (state_q == ST_FILL) ? BLANK_CHAR : cmd_q;

  lcd_ddram #(
    .DEPTH(DDRAM_DEPTH)
  ) u_ddram (
    .clk    (clk),
    .rst    (reset),
    .we_i   (we_d),
    .waddr_i(waddr_d),
    .wdata_i(wdata_d),
    .baddr_i(ac_q),
    .bdata_o(bus_rdata_d),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  always_comb begin
    lcd_data_out = 8'h00;
    if (lcd_rw) lcd_data_out = lcd_rs ? bus_rdata_d : {busy, ac_q};
  end

  // Mode bits with no output of their own are kept for register-level visibility.
  assign unused_mode = ^{s_q, c_q, b_q, dl_q, n_q, f_q};

  assign busy        = ~idle_d;
  assign display_on  = d_q;
  assign cursor_addr = ac_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: table of bus writes with expected AC,
// busy length and DDRAM contents, plus hand sequences for multi-cycle cases.
module tb_lcd_responder;

  localparam int SW    = 16;
  localparam int LW    = 200;
  localparam int DEPTH = 80;
  localparam int LIMIT = LW + DEPTH + 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_enable;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       busy;
  logic       display_on;
  logic [6:0] cursor_addr;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lcd_responder #(
    .SHORT_WAIT (SW),
    .LONG_WAIT  (LW),
    .DDRAM_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lcd_enable  (lcd_enable),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_data_in (lcd_data_in),
    .lcd_data_out(lcd_data_out),
    .busy        (busy),
    .display_on  (display_on),
    .cursor_addr (cursor_addr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .overrun     (overrun)
  );

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         cyc;
    logic [6:0] ac;
    logic       chk;
    logic [6:0] a;
    logic [7:0] m;
  } vec_t;

  vec_t vt[17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs      = rs;
    lcd_rw      = rw;
    lcd_data_in = d;
    lcd_enable  = 1'b1;
    @(negedge clk);
    lcd_enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < LIMIT) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic peek(input logic [6:0] a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1;
    v = rd_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    lcd_enable = 1'b0;
    lcd_rw     = 1'b0;
    lcd_rs     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         n;
    int         nonblank;
    logic [7:0] v;

    vt[0]  = '{1'b0, 8'h85, SW + 1, 7'd5,  1'b0, 7'd0,  8'h00};
    vt[1]  = '{1'b1, 8'h41, SW + 1, 7'd6,  1'b1, 7'd5,  8'h41};
    vt[2]  = '{1'b0, 8'hCF, SW + 1, 7'd79, 1'b0, 7'd0,  8'h00};
    vt[3]  = '{1'b0, 8'h06, SW + 1, 7'd79, 1'b0, 7'd0,  8'h00};
    vt[4]  = '{1'b1, 8'h42, SW + 1, 7'd0,  1'b1, 7'd79, 8'h42};
    vt[5]  = '{1'b0, 8'h04, SW + 1, 7'd0,  1'b0, 7'd0,  8'h00};
    vt[6]  = '{1'b1, 8'h43, SW + 1, 7'd79, 1'b1, 7'd0,  8'h43};
    vt[7]  = '{1'b0, 8'hD0, SW + 1, 7'd0,  1'b0, 7'd0,  8'h00};
    vt[8]  = '{1'b0, 8'h14, SW + 1, 7'd1,  1'b0, 7'd0,  8'h00};
    vt[9]  = '{1'b0, 8'h10, SW + 1, 7'd0,  1'b0, 7'd0,  8'h00};
    vt[10] = '{1'b0, 8'h10, SW + 1, 7'd79, 1'b0, 7'd0,  8'h00};
    vt[11] = '{1'b0, 8'h18, SW + 1, 7'd79, 1'b0, 7'd0,  8'h00};
    vt[12] = '{1'b0, 8'h40, SW + 1, 7'd79, 1'b0, 7'd0,  8'h00};
    vt[13] = '{1'b0, 8'h02, LW + 1, 7'd0,  1'b0, 7'd0,  8'h00};
    vt[14] = '{1'b0, 8'h00, 0,      7'd0,  1'b0, 7'd0,  8'h00};
    vt[15] = '{1'b0, 8'h06, SW + 1, 7'd0,  1'b0, 7'd0,  8'h00};
    vt[16] = '{1'b1, 8'h55, SW + 1, 7'd1,  1'b1, 7'd0,  8'h55};

    reset       = 1'b1;
    lcd_enable  = 1'b0;
    lcd_rs      = 1'b0;
    lcd_rw      = 1'b0;
    lcd_data_in = 8'h00;
    rd_addr     = 7'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_ac", cursor_addr, 0);
    check("reset_overrun", overrun, 0);
    check("reset_dout", lcd_data_out, 8'h00);
    check("reset_rd_data", rd_data, 8'h00);
    check("reset_display_on", display_on, 0);
    check("reset_id", dut.id_q, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      strobe(vt[i].rs, 1'b0, vt[i].d);
      wait_idle(n);
      check($sformatf("vec%0d_busy_cycles", i), n, vt[i].cyc);
      check($sformatf("vec%0d_ac", i), cursor_addr, vt[i].ac);
      if (vt[i].chk) begin
        peek(vt[i].a, v);
        check($sformatf("vec%0d_mem", i), v, vt[i].m);
      end
    end
    check("table_overrun", overrun, 0);

    // Bus data read returns DDRAM[AC] and steps AC with no busy period.
    strobe(1'b0, 1'b0, 8'h80);
    wait_idle(n);
    @(negedge clk);
    lcd_rs = 1'b1;
    lcd_rw = 1'b1;
    #1;
    check("data_read_value", lcd_data_out, 8'h55);
    strobe(1'b1, 1'b1, 8'h00);
    check("data_read_busy", busy, 0);
    check("data_read_ac_step", cursor_addr, 1);
    check("data_read_overrun", overrun, 0);

    // Busy-flag read mid-wait, plus an instruction read while busy, which must be harmless.
    strobe(1'b0, 1'b0, 8'h8A);
    repeat (3) @(posedge clk);
    @(negedge clk);
    lcd_rs = 1'b0;
    lcd_rw = 1'b1;
    #1;
    check("busy_read", lcd_data_out, {1'b1, 7'd10});
    strobe(1'b0, 1'b1, 8'h00);
    strobe(1'b1, 1'b1, 8'h00);
    check("read_while_busy_overrun", overrun, 0);
    wait_idle(n);
    check("read_while_busy_ac", cursor_addr, 10);
    lcd_rw = 1'b0;

    // A data write arriving during busy is dropped and flagged.
    strobe(1'b0, 1'b0, 8'h84);
    wait_idle(n);
    strobe(1'b1, 1'b0, 8'h11);
    wait_idle(n);
    strobe(1'b0, 1'b0, 8'h84);
    strobe(1'b1, 1'b0, 8'h99);
    check("overrun_set", overrun, 1);
    wait_idle(n);
    check("overrun_ac", cursor_addr, 4);
    peek(7'd4, v);
    check("overrun_mem", v, 8'h11);

    // Clear: fill plus long wait, AC home and I/D restored to increment.
    strobe(1'b0, 1'b0, 8'h04);
    wait_idle(n);
    strobe(1'b0, 1'b0, 8'h01);
    wait_idle(n);
    check("clear_busy_cycles", n, DEPTH + LW);
    check("clear_ac", cursor_addr, 0);
    nonblank = 0;
    for (int a = 0; a < DEPTH; a++) begin
      peek(7'(a), v);
      if (v !== 8'h20) nonblank++;
    end
    check("clear_nonblank_count", nonblank, 0);
    strobe(1'b1, 1'b0, 8'h61);
    wait_idle(n);
    check("clear_id_restored", cursor_addr, 1);

    // Reset in the middle of a fill aborts straight to idle.
    strobe(1'b0, 1'b0, 8'h01);
    repeat (10) @(posedge clk);
    #1;
    check("fill_busy_before_reset", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("fill_reset_busy", busy, 0);
    @(posedge clk);
    #1;
    check("fill_reset_busy_edge", busy, 0);
    check("fill_reset_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b0;

    // Falling strobe coincident with reset release is ignored.
    @(negedge clk);
    reset       = 1'b1;
    lcd_rs      = 1'b0;
    lcd_rw      = 1'b0;
    lcd_data_in = 8'h85;
    lcd_enable  = 1'b1;
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    lcd_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_edge_busy", busy, 0);
    check("reset_edge_ac", cursor_addr, 0);

    // Typical initialisation sequence, spaced well past each command's busy time.
    do_reset();
    begin
      logic [7:0] init_seq[5];
      init_seq = '{8'h02, 8'h38, 8'h0C, 8'h06, 8'h01};
      for (int k = 0; k < 5; k++) begin
        strobe(1'b0, 1'b0, init_seq[k]);
        repeat (LW + DEPTH + 20) @(posedge clk);
        #1;
      end
    end
    check("init_overrun", overrun, 0);
    check("init_busy", busy, 0);
    check("init_display_on", display_on, 1);
    check("init_dl", dut.dl_q, 1);
    check("init_n", dut.n_q, 1);
    check("init_id", dut.id_q, 1);
    check("init_ac", cursor_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 SHALL have parameter SHORT_WAIT, default 2_000, busy cycles for ordinary commands and data writes (40 us at 50 MHz).
REQ-002 SHALL have parameter LONG_WAIT, default 40_000, busy cycles for clear and return-home.
REQ-003 SHALL have parameter DDRAM_DEPTH, default 80, number of DDRAM bytes.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port lcd_enable, input, 1, bus strobe, synchronous to clk; a transfer is accepted on its 1->0 transition.
REQ-007 SHALL have port lcd_rs, input, 1, 0 = instruction, 1 = data.
REQ-008 SHALL have port lcd_rw, input, 1, 0 = write, 1 = read.
REQ-009 SHALL have port lcd_data_in, input, 8, write data bus.
REQ-010 SHALL have port lcd_data_out, output, 8, read data bus.
REQ-011 SHALL have port busy, output, 1, busy flag.
REQ-012 SHALL have port display_on, output, 1, D bit of display control.
REQ-013 SHALL have port cursor_addr, output, 7, address counter (AC).
REQ-014 SHALL have port rd_addr, input, 7, renderer read address.
REQ-015 SHALL have port rd_data, output, 8, DDRAM[rd_addr], registered with 1-cycle latency.
REQ-016 SHALL have port overrun, output, 1, sticky flag: a write strobe arrived while busy.

Function
REQ-017 SHALL register lcd_enable once and detect a strobe as prev=1 and current=0, giving one accept pulse per falling edge.
REQ-018 On an accepted write while busy=0, SHALL sample lcd_rs, lcd_rw and lcd_data_in in that same cycle.
REQ-019 SHALL decode instructions by highest set bit:
  - 0x01 clear: fill DDRAM with 0x20 one address per cycle (DDRAM_DEPTH cycles), then AC=0, I/D=1, then LONG_WAIT.
  - 0x02-0x03 return home: AC=0, then LONG_WAIT.
  - 0x04-0x07 entry mode: store I/D=bit1 and S=bit0 (S stored only, no shift), then SHORT_WAIT.
  - 0x08-0x0F display control: store D, C, B (bits 2..0), then SHORT_WAIT.
  - 0x10-0x1F cursor/shift: with S/C=0, move AC by R/L (bit2: 1 = +1, 0 = -1); with S/C=1, no-op; then SHORT_WAIT.
  - 0x20-0x3F function set: store DL, N, F (bits 4..2), then SHORT_WAIT.
  - 0x40-0x7F CGRAM address: ignored, then SHORT_WAIT.
  - 0x80-0xFF: AC = data[6:0], clamped to 0 if >= DDRAM_DEPTH, then SHORT_WAIT.
  - 0x00: no-op, busy not asserted.
REQ-020 On a data write (rs=1, rw=0), SHALL set DDRAM[AC]=data and step AC by I/D, then SHORT_WAIT.
REQ-021 AC SHALL wrap at the DDRAM_DEPTH-1 -> 0 increment and the 0 -> DDRAM_DEPTH-1 decrement.
REQ-022 State machine: IDLE -> EXEC (1 cycle, apply effect) -> WAIT; clear: IDLE -> FILL -> WAIT; WAIT -> IDLE when the timer reaches its load value.
REQ-023 busy SHALL be 1 in EXEC, FILL and WAIT, and 0 only in IDLE.
REQ-024 A write strobe while busy=1 SHALL be dropped with no state change and SHALL set overrun.
REQ-025 For reads (rw=1), lcd_data_out SHALL be {busy, AC} when rs=0, and DDRAM[AC] when rs=1.
REQ-026 A read with rs=0 SHALL be allowed while busy and SHALL have no side effects.
REQ-027 A read with rs=1 SHALL step AC by I/D on the strobe when idle, and SHALL be ignored (no overrun) when busy.
REQ-028 lcd_data_out SHALL update combinationally from the current registers.
REQ-029 The renderer port SHALL be independent of bus traffic; during FILL it returns either old data or 0x20.
REQ-030 The wait timer SHALL be 17 bits wide.

Reset
REQ-031 Reset SHALL give: state IDLE, AC=0, I/D=1, S=0, D=C=B=0, DL=N=F=0, busy=0, overrun=0, lcd_data_out=0x00, rd_data=0x00.
REQ-032 Reset SHALL leave DDRAM contents undefined.
REQ-033 Reset mid-FILL or mid-WAIT SHALL abort to IDLE immediately.
REQ-034 A falling strobe edge coincident with reset deassertion SHALL be ignored, because the prev register resets to 0.

Structure
REQ-035 A shared package SHALL hold the state encoding, the instruction-class decode constants, and the 0x20 blank character.
REQ-036 DDRAM SHALL be a sub-module lcd_ddram: simple dual-port, one write port, one async read port for the bus, one registered read port for the renderer.

Verification
REQ-037 Reset, then strobe instruction 0x80|0x05 followed by data 0x41 -> DDRAM[5]=0x41, AC=6, busy high for SHORT_WAIT+1 cycles per transfer.
REQ-038 Send 0x01 -> busy held for 80+LONG_WAIT cycles; DDRAM[0..79] all 0x20; AC=0.
REQ-039 Send 0x84 then strobe data during busy -> overrun=1, DDRAM[4] unchanged, AC unchanged.
REQ-040 Set AC=79, entry mode 0x06, write 0x42 -> AC=0; then entry mode 0x04, write 0x43 -> DDRAM[0]=0x43, AC=79.
REQ-041 Send sequence 0x02,0x38,0x0C,0x06,0x01 at 50_000-cycle spacing -> overrun=0, DL=N=1, D=1, I/D=1, display_on=1.
REQ-042 Busy read (rs=0, rw=1) mid-WAIT returns bit7=1; assert reset mid-FILL -> busy=0 on the next edge.
